// File: rtl/med_pkg.sv
// rtl/med_pkg.sv - shared state enum and counter-width helpers for the median sequencer
package med_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pass counter spans P = (N+1)/2 passes.
  function automatic int pass_w(input int n);
    return cnt_w((n + 1) / 2);
  endfunction

endpackage

// File: rtl/med_seq_mce.sv
// rtl/med_seq_mce.sv - unsigned compare-exchange cell
module med_seq_mce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN
);

  logic a_ge_b;

  assign a_ge_b = (A >= B);
  assign MAX    = a_ge_b ? A : B;
  assign MIN    = a_ge_b ? B : A;

endmodule

// File: rtl/med_seq.sv
// rtl/med_seq.sv - sequential median filter over non-overlapping windows of N samples
// Each pass rotates the ring through one compare-exchange; pass P's winner is the median.
module med_seq
  import med_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic             RDY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
);

  localparam int P  = (N + 1) / 2;
  localparam int CW = cnt_w(N);
  localparam int PW = pass_w(N);
  localparam logic [CW-1:0] LAST_CYC  = CW'(N - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(P - 1);

  if (N < 3 || (N % 2) == 0 || WIDTH < 1) begin : g_bad_param
    $error("med_seq: N must be odd and >= 3, WIDTH must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    smp_q, smp_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [WIDTH-1:0] ring_q [N];
  logic [WIDTH-1:0] ring_d [N];
  logic [N-1:0]     rm_q, rm_d;
  logic [WIDTH-1:0] car_q, car_d;
  logic             car_rm_q, car_rm_d;
  logic [WIDTH-1:0] do_q, do_d;

  logic [WIDTH-1:0] cx_max, cx_min, win, lose;
  logic             win_rm, lose_rm;

  med_seq_mce #(.WIDTH(WIDTH)) u_mce (
    .A   (car_q),
    .B   (ring_q[0]),
    .MAX (cx_max),
    .MIN (cx_min)
  );

  // Removed entries always lose, so they sink back into the ring and never become the carry winner.
  always_comb begin
    win     = cx_max;
    win_rm  = 1'b0;
    lose    = cx_min;
    lose_rm = 1'b0;
    if (rm_q[0]) begin
      win     = car_q;
      win_rm  = car_rm_q;
      lose    = ring_q[0];
      lose_rm = 1'b1;
    end else if (car_rm_q) begin
      win     = ring_q[0];
      win_rm  = 1'b0;
      lose    = car_q;
      lose_rm = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    cyc_d    = cyc_q;
    pass_d   = pass_q;
    ring_d   = ring_q;
    rm_d     = rm_q;
    car_d    = car_q;
    car_rm_d = car_rm_q;
    do_d     = do_q;
    unique case (state_q)
      LOAD: begin
        car_rm_d = 1'b1;
        if (DSI) begin
          for (int i = 0; i < N - 1; i++) ring_d[i] = ring_q[i+1];
          ring_d[N-1] = DI;
          rm_d        = {1'b0, rm_q[N-1:1]};
          if (smp_q == LAST_CYC) begin
            smp_d   = '0;
            cyc_d   = '0;
            pass_d  = '0;
            state_d = COMPUTE;
          end else begin
            smp_d = smp_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        for (int i = 0; i < N - 1; i++) ring_d[i] = ring_q[i+1];
        ring_d[N-1] = lose;
        rm_d        = {lose_rm, rm_q[N-1:1]};
        car_d       = win;
        car_rm_d    = win_rm;
        if (cyc_q == LAST_CYC) begin
          cyc_d    = '0;
          car_rm_d = 1'b1;
          if (pass_q == LAST_PASS) begin
            do_d    = win;
            state_d = OUT;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      OUT: begin
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= LOAD;
      smp_q    <= '0;
      cyc_q    <= '0;
      pass_q   <= '0;
      rm_q     <= '0;
      car_q    <= '0;
      car_rm_q <= 1'b1;
      do_q     <= '0;
      for (int i = 0; i < N; i++) ring_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      cyc_q    <= cyc_d;
      pass_q   <= pass_d;
      rm_q     <= rm_d;
      car_q    <= car_d;
      car_rm_q <= car_rm_d;
      do_q     <= do_d;
      ring_q   <= ring_d;
    end
  end

  assign RDY = (state_q == LOAD);
  assign DSO = (state_q == OUT);
  assign DO  = do_q;

endmodule

// File: tb/tb_med_seq.sv
// tb/tb_med_seq.sv - self-checking bench for med_seq (N=9/WIDTH=8 and N=3/WIDTH=4 instances)
module tb_med_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] di, dout;
  logic       dsi, rdy, dso;
  logic [3:0] di3, dout3;
  logic       dsi3, rdy3, dso3;

  med_seq #(.WIDTH(8), .N(9)) dut (
    .CLK(clk), .RST(rst), .DI(di), .DSI(dsi), .RDY(rdy), .DO(dout), .DSO(dso)
  );

  med_seq #(.WIDTH(4), .N(3)) dut3 (
    .CLK(clk), .RST(rst), .DI(di3), .DSI(dsi3), .RDY(rdy3), .DO(dout3), .DSO(dso3)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [71:0] s;
    logic [7:0]  exp;
    logic        hold;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: ascending sort, middle element is the ((N+1)/2)-th largest.
  function automatic int ref_median(input int q[$]);
    int s[$];
    s = q;
    s.sort();
    return s[s.size() / 2];
  endfunction

  task automatic run9(input logic [71:0] s, input logic hold, input logic [7:0] exp, input int id);
    int k, lowc;
    logic seen;
    chk($sformatf("w%0d rdy_at_start", id), rdy, 1);
    for (int i = 0; i < 9; i++) begin
      di  = s[8*(8-i) +: 8];
      dsi = 1'b1;
      @(posedge clk); #1;
    end
    if (hold) di = 8'hAA; else dsi = 1'b0;
    lowc = (rdy == 1'b0) ? 1 : 0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (!rdy) lowc++;
      if (dso) seen = 1'b1;
    end
    dsi = 1'b0;
    chk($sformatf("w%0d latency", id), k, 45);
    chk($sformatf("w%0d median", id), dout, exp);
    chk($sformatf("w%0d rdy_low_cycles", id), lowc, 46);
    @(posedge clk); #1;
    chk($sformatf("w%0d dso_single", id), dso, 0);
    chk($sformatf("w%0d rdy_back", id), rdy, 1);
    chk($sformatf("w%0d do_hold", id), dout, exp);
  endtask

  task automatic run3(input logic [11:0] s, input logic [3:0] exp, input int id);
    int k;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      di3  = s[4*(2-i) +: 4];
      dsi3 = 1'b1;
      @(posedge clk); #1;
    end
    dsi3 = 1'b0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (dso3) seen = 1'b1;
    end
    chk($sformatf("n3 w%0d latency", id), k, 6);
    chk($sformatf("n3 w%0d median", id), dout3, exp);
    @(posedge clk); #1;
    chk($sformatf("n3 w%0d dso_single", id), dso3, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int expq[$];
    int wins, dsos, cyc, pulses;

    tbl[0] = '{{8'd7, 8'd3, 8'd9, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd5, 1'b0};
    tbl[1] = '{{9{8'hFF}}, 8'hFF, 1'b0};
    tbl[2] = '{{{4{8'd0}}, {5{8'd255}}}, 8'd255, 1'b0};
    tbl[3] = '{{{5{8'd0}}, {4{8'd255}}}, 8'd0, 1'b0};
    tbl[4] = '{{8'd9, 8'd1, 8'd200, 8'd17, 8'd17, 8'd3, 8'd250, 8'd17, 8'd5}, 8'd17, 1'b1};
    tbl[5] = '{{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, 8'd50, 1'b0};
    tbl[6] = '{{8'd128, 8'd127, 8'd129, 8'd128, 8'd0, 8'd255, 8'd128, 8'd1, 8'd254}, 8'd128, 1'b0};

    rst = 1'b1; di = '0; dsi = 1'b0; di3 = '0; dsi3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdy", rdy, 1);
    chk("reset dso", dso, 0);
    chk("reset do", dout, 0);
    chk("reset rdy n3", rdy3, 1);
    chk("reset do n3", dout3, 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run9(tbl[v].s, tbl[v].hold, tbl[v].exp, v);

    run3({4'd15, 4'd0, 4'd7}, 4'd7, 0);
    run3({4'd3, 4'd3, 4'd1}, 4'd3, 1);

    // Reset asserted at COMPUTE cycle 20 must discard the window.
    for (int i = 0; i < 9; i++) begin
      di  = 8'(200 + i);
      dsi = 1'b1;
      @(posedge clk); #1;
    end
    dsi = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst do", dout, 0);
    chk("midrst rdy", rdy, 1);
    chk("midrst dso", dso, 0);
    @(posedge clk); #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (dso) pulses++;
    end
    chk("midrst no_dso", pulses, 0);
    run9({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b0, 8'd5, 100);

    wins = 0; dsos = 0; cyc = 0;
    while ((wins < 100 || expq.size() > 0) && cyc < 20000) begin
      logic acc;
      if (wins < 100) begin
        dsi = 1'b1;
        di  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end else begin
        dsi = 1'b0;
      end
      acc = dsi && rdy;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        q.push_back(int'(di));
        if (q.size() == 9) begin
          expq.push_back(ref_median(q));
          q.delete();
          wins++;
        end
      end
      if (dso) begin
        dsos++;
        if (expq.size() == 0) chk("rnd spurious_dso", 1, 0);
        else chk($sformatf("rnd window %0d", dsos), dout, expq.pop_front());
      end
    end
    chk("rnd dso_count", dsos, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
